instr_fetch_unit: RTL and testbench

//   Front-end fetch stage. Drives the read port 1 address/enable of the 2048x32

---
 rtl/instr_fetch_unit.sv | 134 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Front-end fetch stage: issues reads with a fixed 1-cycle latency, buffers returned words
// with their PC in a prefetch FIFO, and hands them to decode. A redirect flushes and restarts.
module instr_fetch_unit #(
    parameter int                ADDR_W     = 11,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                        clk,
    input  logic                        resetn,
    output logic [ADDR_W-1:0]           mem_r_adrs,
    output logic                        mem_r_en,
    input  logic                        mem_r_valid,
    input  logic [DATA_W-1:0]           mem_r_data,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [DATA_W-1:0]           instr_data,
    output logic [ADDR_W-1:0]           instr_pc,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_FILLING,
        ST_FULL,
        ST_FLUSH
    } fetch_state_e;

    fetch_state_e      state;

    logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
    logic              inflight_q,    inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [CNT_W-1:0]  count_q,       count_d;

    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              has_credit;
    logic              issue;
    logic              push;
    logic              pop;

    // An outstanding read already owns a FIFO slot, so it is counted against the credit.
    assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign has_credit = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state = ST_FILLING;
        if (redirect) begin
            state = ST_FLUSH;
        end else if (!has_credit) begin
            state = ST_FULL;
        end
    end

    assign issue       = resetn && (state == ST_FILLING);
    assign push        = mem_r_valid && inflight_q && !redirect;
    assign instr_valid = resetn && (count_q != '0);
    assign pop         = instr_valid && instr_ready && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = issue;
        inflight_pc_d = fetch_pc_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= mem_r_data;
            fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    assign mem_r_en   = issue;
    assign mem_r_adrs = fetch_pc_q;
    assign instr_data = instr_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign instr_pc   = instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;
    assign fifo_count = resetn ? count_q : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a 1-cycle-latency memory model with an override
// that injects unsolicited valid pulses, plus hand-computed expectations.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic [10:0] mem_r_adrs;
    logic        mem_r_en;
    logic        mem_r_valid;
    logic [31:0] mem_r_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [10:0] instr_pc;
    logic        redirect;
    logic [10:0] redirect_pc;
    logic [2:0]  fifo_count;

    logic [31:0] mem [2048];
    logic        mem_valid_q = 1'b0;
    logic [31:0] mem_data_q  = '0;
    logic        force_valid;
    logic [31:0] force_data;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_r_adrs  (mem_r_adrs),
        .mem_r_en    (mem_r_en),
        .mem_r_valid (mem_r_valid),
        .mem_r_data  (mem_r_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_valid_q <= mem_r_en;
        mem_data_q  <= mem[mem_r_adrs];
    end

    assign mem_r_valid = force_valid | mem_valid_q;
    assign mem_r_data  = force_valid ? force_data : mem_data_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        force_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reads;
        int got;

        for (int i = 0; i < 2048; i++) mem[i] = 32'h100 + i;
        resetn      = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        force_valid = 1'b0;
        force_data  = '0;
        repeat (3) tick();

        // Reset state
        check("rst_en",    mem_r_en,    0);
        check("rst_adrs",  mem_r_adrs,  0);
        check("rst_valid", instr_valid, 0);
        check("rst_data",  instr_data,  0);
        check("rst_pc",    instr_pc,    0);
        check("rst_count", fifo_count,  0);

        // Streaming from reset: first word at cycle 2, then one per cycle
        resetn      = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("t1_c0_en",    mem_r_en,    1);
        check("t1_c0_adrs",  mem_r_adrs,  0);
        check("t1_c0_valid", instr_valid, 0);
        tick();
        check("t1_c1_adrs",  mem_r_adrs,  1);
        check("t1_c1_valid", instr_valid, 0);
        tick();
        check("t1_c2_valid", instr_valid, 1);
        check("t1_c2_pc",    instr_pc,    0);
        check("t1_c2_data",  instr_data,  32'h100);
        check("t1_c2_count", fifo_count,  1);
        for (int k = 1; k < 8; k++) begin
            tick();
            check("t1_stream_valid", instr_valid, 1);
            check("t1_stream_pc",    instr_pc,    k);
            check("t1_stream_data",  instr_data,  32'h100 + k);
        end

        // Decode stalled: exactly four reads, then hold full
        do_reset();
        resetn = 1'b1;
        #1;
        reads = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_r_en) begin
                check("t2_read_adrs", mem_r_adrs, reads);
                reads++;
            end
            tick();
        end
        check("t2_reads",     reads,       4);
        check("t2_count",     fifo_count,  4);
        check("t2_en_held",   mem_r_en,    0);
        check("t2_next_adrs", mem_r_adrs,  4);
        check("t2_head_pc",   instr_pc,    0);
        instr_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 8; c++) begin
            if (instr_valid) begin
                check("t2_drain_pc",   instr_pc,   got);
                check("t2_drain_data", instr_data, 32'h100 + got);
                got++;
            end
            tick();
        end
        check("t2_drained", got, 8);

        // Redirect to 0x7FE while streaming, in a cycle with a response and a pop
        do_reset();
        resetn      = 1'b1;
        instr_ready = 1'b1;
        repeat (5) tick();
        check("t3_c5_pc",     instr_pc,    3);
        check("t3_c5_mvalid", mem_r_valid, 1);
        check("t3_c5_ivalid", instr_valid, 1);
        redirect    = 1'b1;
        redirect_pc = 11'h7FE;
        #1;
        check("t3_flush_en", mem_r_en, 0);
        tick();
        redirect    = 1'b0;
        force_valid = 1'b1;
        force_data  = 32'hDEADBEEF;
        #1;
        check("t3_c6_adrs",  mem_r_adrs,  11'h7FE);
        check("t3_c6_en",    mem_r_en,    1);
        check("t3_c6_count", fifo_count,  0);
        check("t3_c6_valid", instr_valid, 0);
        tick();
        force_valid = 1'b0;
        #1;
        check("t6_no_push_count", fifo_count,  0);
        check("t3_c7_valid",      instr_valid, 0);
        check("t3_c7_mvalid",     mem_r_valid, 1);
        tick();
        check("t3_c8_valid", instr_valid, 1);
        check("t3_c8_pc",    instr_pc,    11'h7FE);
        check("t3_c8_data",  instr_data,  32'h8FE);
        tick();
        check("t3_c9_pc",    instr_pc,    11'h7FF);
        check("t3_c9_data",  instr_data,  32'h8FF);
        tick();
        check("t3_c10_pc",   instr_pc,    0);
        check("t3_c10_data", instr_data,  32'h100);

        // Second redirect coinciding with response and valid&ready
        tick();
        check("t4_pre_pc",     instr_pc,    1);
        check("t4_pre_mvalid", mem_r_valid, 1);
        check("t4_pre_ivalid", instr_valid, 1);
        redirect    = 1'b1;
        redirect_pc = 11'h123;
        tick();
        redirect = 1'b0;
        #1;
        check("t4_count", fifo_count,  0);
        check("t4_valid", instr_valid, 0);
        check("t4_adrs",  mem_r_adrs,  11'h123);
        tick();
        check("t4_gap_valid", instr_valid, 0);
        tick();
        check("t4_first_valid", instr_valid, 1);
        check("t4_first_pc",    instr_pc,    11'h123);
        check("t4_first_data",  instr_data,  32'h223);
        tick();
        check("t4_second_pc",   instr_pc,    11'h124);

        // Full FIFO: unsolicited valid ignored, then reset mid-operation
        do_reset();
        resetn = 1'b1;
        repeat (8) tick();
        check("t5_full_count", fifo_count, 4);
        force_valid = 1'b1;
        force_data  = 32'hDEADBEEF;
        tick();
        force_valid = 1'b0;
        #1;
        check("t6_full_count", fifo_count, 4);
        check("t6_full_en",    mem_r_en,   0);
        check("t6_head_data",  instr_data, 32'h100);
        resetn = 1'b0;
        #1;
        check("t5_rst_valid", instr_valid, 0);
        check("t5_rst_count", fifo_count,  0);
        check("t5_rst_en",    mem_r_en,    0);
        check("t5_rst_data",  instr_data,  0);
        tick();
        resetn      = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("t5_rel_en",    mem_r_en,   1);
        check("t5_rel_adrs",  mem_r_adrs, 0);
        check("t5_rel_count", fifo_count, 0);
        tick();
        tick();
        check("t5_first_valid", instr_valid, 1);
        check("t5_first_pc",    instr_pc,    0);
        check("t5_first_data",  instr_data,  32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
